// File: rtl/decode_seq.sv
`default_nettype none
// ============================================================================
// Module  : decode_seq
// Brief   : Handshaked decode stage; latches fields, sequences Rn/Rm reads.
// Revision: 1.0
// ============================================================================
module decode_seq #(
    parameter int DATA_W  = 16,
    parameter bit SKIP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instruction,
    output logic              rd_en,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  shift_q, shift_d;
    logic [2:0]  rm_q, rm_d;
    logic [7:0]  imm8_q, imm8_d;
    logic [2:0]  readnum_q, readnum_d;
    logic [2:0]  writenum_q, writenum_d;
    logic        need_b_q, need_b_d;

    logic [2:0]  w_opc;
    logic [1:0]  w_op;
    logic        w_mov_imm;
    logic        w_mov_reg;
    logic        w_mvn;
    logic        w_need_a;
    logic        w_need_b;

    // Operand needs are decoded straight from the incoming word at accept time.
    assign w_opc     = instruction[15:13];
    assign w_op      = instruction[12:11];
    assign w_mov_imm = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_mvn     = (w_opc == 3'b101) && (w_op == 2'b11);
    assign w_need_a  = !SKIP_EN || !(w_mov_imm || w_mov_reg || w_mvn);
    assign w_need_b  = !SKIP_EN || !w_mov_imm;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        op_d       = op_q;
        shift_d    = shift_q;
        rm_d       = rm_q;
        imm8_d     = imm8_q;
        readnum_d  = readnum_q;
        writenum_d = writenum_q;
        need_b_d   = need_b_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opcode_d   = w_opc;
                    op_d       = w_op;
                    shift_d    = instruction[4:3];
                    rm_d       = instruction[2:0];
                    imm8_d     = instruction[7:0];
                    writenum_d = (w_opc == 3'b110) ? instruction[10:8] : instruction[7:5];
                    need_b_d   = w_need_b;
                    if (w_need_a) begin
                        state_d   = RD_A;
                        readnum_d = instruction[10:8];
                    end else if (w_need_b) begin
                        state_d   = RD_B;
                        readnum_d = instruction[2:0];
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            RD_A: begin
                if (need_b_q) begin
                    state_d   = RD_B;
                    readnum_d = rm_q;
                end else begin
                    state_d   = DONE;
                end
            end
            RD_B: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            opcode_q   <= 3'd0;
            op_q       <= 2'd0;
            shift_q    <= 2'd0;
            rm_q       <= 3'd0;
            imm8_q     <= 8'd0;
            readnum_q  <= 3'd0;
            writenum_q <= 3'd0;
            need_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            op_q       <= op_d;
            shift_q    <= shift_d;
            rm_q       <= rm_d;
            imm8_q     <= imm8_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            need_b_q   <= need_b_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rd_en     = (state_q == RD_A) || (state_q == RD_B);
    assign readnum   = readnum_q;
    assign writenum  = writenum_q;
    assign opcode    = opcode_q;
    assign op        = op_q;
    assign shift     = shift_q;
    assign sximm5    = {{(DATA_W-5){imm8_q[4]}}, imm8_q[4:0]};
    assign sximm8    = {{(DATA_W-8){imm8_q[7]}}, imm8_q};

endmodule
`default_nettype wire
